// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared types and constants for the sequential shifter
package shift_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift by 0..STEP positions with shifted-out OR
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int AW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [AW-1:0]    i_amount,
  input  logic             i_dir,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_value,
  output logic             o_lost
);

  localparam logic [WIDTH-1:0] ONES = '1;

  // One arm per legal amount keeps every shift constant after unrolling.
  always_comb begin
    o_value = i_value;
    o_lost  = 1'b0;
    for (int k = 1; k <= STEP; k++) begin
      if (i_amount == AW'(k)) begin
        if (i_dir == DIR_LEFT) begin
          o_value = i_value << k;
          o_lost  = |(i_value >> (WIDTH - k));
        end else begin
          o_value = (i_value >> k) | (i_fill ? ~(ONES >> k) : '0);
          o_lost  = |(i_value & ~(ONES << k));
        end
      end
    end
  end

endmodule

// File: rtl/shift_reg_seq.sv
// rtl/shift_reg_seq.sv - handshaked iterative shifter, up to STEP positions per clock
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic               dir,
  input  logic               arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               ovf,
  output logic               busy
);

  localparam int AW = $clog2(STEP + 1);

  state_t             r_state;
  state_t             w_next;
  logic [SHAMT_W-1:0] r_rem;
  logic [WIDTH-1:0]   r_data;
  logic               r_ovf;
  logic               r_dir;
  logic               r_arith;

  logic               w_accept;
  logic [SHAMT_W-1:0] w_rem_init;
  logic [AW-1:0]      w_step_amt;
  logic [SHAMT_W-1:0] w_rem_next;
  logic               w_fill;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_lost;

  assign w_accept   = in_valid & in_ready;
  assign w_rem_init = (shift_amt > SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : shift_amt;
  assign w_step_amt = (r_rem > SHAMT_W'(STEP)) ? AW'(STEP) : r_rem[AW-1:0];
  assign w_rem_next = r_rem - SHAMT_W'(w_step_amt);
  // The sign bit never changes under an arithmetic right shift, so the
  // working register's MSB is the captured MSB throughout.
  assign w_fill     = r_arith & (r_dir == DIR_RIGHT) & r_data[WIDTH-1];

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_value  (r_data),
    .i_amount (w_step_amt),
    .i_dir    (r_dir),
    .i_fill   (w_fill),
    .o_value  (w_shifted),
    .o_lost   (w_lost)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_rem_init == '0) ? DONE : SHIFT;
      SHIFT:   if (w_rem_next == '0) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_rem   <= '0;
      r_dir   <= DIR_LEFT;
      r_arith <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data  <= data_in;
            r_dir   <= dir;
            r_arith <= arith;
            r_rem   <= w_rem_init;
            r_ovf   <= 1'b0;
          end
        end
        SHIFT: begin
          r_data <= w_shifted;
          r_ovf  <= r_ovf | w_lost;
          r_rem  <= w_rem_next;
        end
        default: ;
      endcase
    end
  end

  assign data_out = r_data;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb/tb_shift_reg_seq.sv - scoreboard bench for shift_reg_seq at STEP=1 and STEP=4
module tb_shift_reg_seq;

  localparam int W  = 8;
  localparam int SW = 4;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid[2];
  logic         in_ready[2];
  logic [W-1:0] data_in[2];
  logic [SW-1:0] shift_amt[2];
  logic         dir[2];
  logic         arith[2];
  logic         out_valid[2];
  logic         out_ready[2];
  logic [W-1:0] data_out[2];
  logic         ovf[2];
  logic         busy[2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   rand_rdy = 1'b0;
  bit   prev_v[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_reg_seq #(.WIDTH(W), .SHAMT_W(SW), .STEP(1)) u_dut_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .data_in   (data_in[0]),
    .shift_amt (shift_amt[0]),
    .dir       (dir[0]),
    .arith     (arith[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .data_out  (data_out[0]),
    .ovf       (ovf[0]),
    .busy      (busy[0])
  );

  shift_reg_seq #(.WIDTH(W), .SHAMT_W(SW), .STEP(4)) u_dut_s4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .data_in   (data_in[1]),
    .shift_amt (shift_amt[1]),
    .dir       (dir[1]),
    .arith     (arith[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .data_out  (data_out[1]),
    .ovf       (ovf[1]),
    .busy      (busy[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Shift semantics as integer arithmetic: multiply/divide by 2^n, floor for signed.
  task automatic ref_model(input int v, input int amt, input bit dr, input bit ar,
                           input int step, output int r, output int o, output int n);
    int s;
    int p;
    int sv;
    s = (amt > W) ? W : amt;
    p = 1 << s;
    n = (s + step - 1) / step;
    if (!dr) begin
      r = (v * p) % (1 << W);
      o = ((v >> (W - s)) != 0) ? 1 : 0;
    end else begin
      o = ((v % p) != 0) ? 1 : 0;
      if (ar && v >= (1 << (W - 1))) begin
        sv = v - (1 << W);
        r  = -((-sv + p - 1) / p);
        r  = r & ((1 << W) - 1);
      end else begin
        r = v / p;
      end
    end
  endtask

  task automatic send_exp(input int d, input int v, input int amt, input bit dr, input bit ar,
                          input int edata, input int eovf, input int en);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!in_ready[d] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[d]) begin
      fail_now($sformatf("dut%0d_accept", d));
      return;
    end
    in_valid[d]  = 1'b1;
    data_in[d]   = W'(v);
    shift_amt[d] = SW'(amt);
    dir[d]       = dr;
    arith[d]     = ar;
    e.data = W'(edata);
    e.ovf  = eovf[0];
    e.due  = cyc + 1 + en;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    in_valid[d]  = 1'b0;
    data_in[d]   = W'($urandom);
    shift_amt[d] = SW'($urandom);
    dir[d]       = 1'($urandom);
    arith[d]     = 1'($urandom);
  endtask

  task automatic send_rand(input int d);
    int v, amt, r, o, n;
    bit dr, ar;
    v   = $urandom_range(0, 255);
    amt = $urandom_range(0, 15);
    dr  = 1'($urandom);
    ar  = 1'($urandom);
    ref_model(v, amt, dr, ar, (d == 0) ? 1 : 4, r, o, n);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    send_exp(d, v, amt, dr, ar, r, o, n);
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (qsize(d) != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (qsize(d) != 0) fail_now($sformatf("dut%0d_drain", d));
  endtask

  task automatic set_rdy(input int d, input logic v);
    @(posedge clk);
    #2;
    out_ready[d] = v;
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_dut%0d_data_out", tag, d), data_out[d], 0);
      chk($sformatf("%s_dut%0d_ovf", tag, d), ovf[d], 0);
      chk($sformatf("%s_dut%0d_out_valid", tag, d), out_valid[d], 0);
      chk($sformatf("%s_dut%0d_busy", tag, d), busy[d], 0);
      chk($sformatf("%s_dut%0d_in_ready", tag, d), in_ready[d], 1);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_rdy) begin
      for (int d = 0; d < 2; d++) out_ready[d] = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every presented result against the queue head.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      if (!rst_n) begin
        prev_v[d] = 1'b0;
      end else if (out_valid[d]) begin
        if (qsize(d) == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut%0d_unexpected_output: got data_out=%02h with no request outstanding",
                   d, data_out[d]);
        end else begin
          if (d == 0) e = q0[0]; else e = q1[0];
          chk($sformatf("dut%0d_data_out", d), data_out[d], e.data);
          chk($sformatf("dut%0d_ovf", d), ovf[d], e.ovf);
          chk($sformatf("dut%0d_in_ready_in_done", d), in_ready[d], 0);
          chk($sformatf("dut%0d_busy_in_done", d), busy[d], 1);
          if (!prev_v[d]) chk($sformatf("dut%0d_latency", d), cyc, e.due);
          if (out_ready[d]) begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
        end
        prev_v[d] = 1'b1;
      end else begin
        prev_v[d] = 1'b0;
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      data_in[d]   = '0;
      shift_amt[d] = '0;
      dir[d]       = 1'b0;
      arith[d]     = 1'b0;
      out_ready[d] = 1'b1;
      prev_v[d]    = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    send_exp(0, 8'h55, 1, 1'b1, 1'b0, 8'h2A, 1, 1);
    drain(0);
    send_exp(0, 8'h81, 3, 1'b1, 1'b1, 8'hF0, 1, 3);
    drain(0);
    send_exp(1, 8'hFF, 12, 1'b0, 1'b0, 8'h00, 1, 2);
    drain(1);

    set_rdy(0, 1'b0);
    send_exp(0, 8'hFF, 0, 1'b0, 1'b0, 8'hFF, 0, 0);
    in_valid[0]  = 1'b1;
    data_in[0]   = 8'h11;
    shift_amt[0] = SW'(2);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    repeat (4) @(negedge clk);
    set_rdy(0, 1'b1);
    drain(0);
    repeat (3) @(negedge clk);
    chk("stall_no_recapture_out_valid", out_valid[0], 0);
    chk("stall_no_recapture_busy", busy[0], 0);

    send_exp(0, 8'hB7, 6, 1'b1, 1'b0, 8'h02, 1, 6);
    repeat (2) @(negedge clk);
    chk("mid_shift_busy", busy[0], 1);
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_exp(0, 8'h01, 2, 1'b0, 1'b0, 8'h04, 0, 2);
    drain(0);

    rand_rdy = 1'b1;
    fork
      repeat (60) send_rand(0);
      repeat (60) send_rand(1);
    join
    drain(0);
    drain(1);
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
